// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - writeback, issue and read-port bundle for regfile_sb
interface regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2
);
  localparam int AW = $clog2(NREGS);

  logic                    i_we;
  logic [AW-1:0]           i_dest_addr;
  logic [XLEN-1:0]         i_data;
  logic                    i_issue_valid;
  logic [AW-1:0]           i_issue_addr;
  logic [NREAD*AW-1:0]     i_rd_addr;
  logic [NREAD*XLEN-1:0]   o_rd_data;
  logic [NREAD-1:0]        o_rd_busy;
  logic                    o_ready;

  modport master (
    output i_we, i_dest_addr, i_data, i_issue_valid, i_issue_addr, i_rd_addr,
    input  o_rd_data, o_rd_busy, o_ready
  );

  modport slave (
    input  i_we, i_dest_addr, i_data, i_issue_valid, i_issue_addr, i_rd_addr,
    output o_rd_data, o_rd_busy, o_ready
  );
endinterface

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with bypass, scoreboard and reset sweep
module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2
) (
  input  logic          clk,
  input  logic          rst,
  regfile_sb_if.slave   bus
);
  localparam int AW = $clog2(NREGS);

  typedef enum logic [0:0] {ST_INIT, ST_RUN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [AW-1:0]       r_cnt;
  logic [XLEN-1:0]     r_regs [NREGS];
  logic [NREGS-1:0]    r_pending;
  logic                w_run;
  logic                w_wr_en;
  logic                w_iss_en;
  logic [NREAD*XLEN-1:0] w_rd_data;
  logic [NREAD-1:0]      w_rd_busy;

  assign w_run    = (r_state == ST_RUN);
  assign w_wr_en  = w_run && bus.i_we && (bus.i_dest_addr != '0);
  assign w_iss_en = w_run && bus.i_issue_valid && (bus.i_issue_addr != '0);

  // State register; reset always restarts the clearing sweep
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_INIT;
    else     r_state <= w_state_nxt;
  end

  // Leave INIT once the last index has been cleared
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ST_INIT && r_cnt == AW'(NREGS - 1)) w_state_nxt = ST_RUN;
  end

  // Sweep counter walks every index once while in INIT
  always_ff @(posedge clk) begin
    if (rst)                   r_cnt <= '0;
    else if (r_state == ST_INIT) r_cnt <= r_cnt + AW'(1);
  end

  // Register array has no reset so it can map to RAM; the sweep zeroes it
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == ST_INIT) r_regs[r_cnt] <= '0;
      else if (w_wr_en)       r_regs[bus.i_dest_addr] <= bus.i_data;
    end
  end

  // Scoreboard: writeback clears, issue sets, and issue wins on a collision
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
    end else if (r_state == ST_INIT) begin
      r_pending[r_cnt] <= 1'b0;
    end else begin
      if (w_wr_en)  r_pending[bus.i_dest_addr]  <= 1'b0;
      if (w_iss_en) r_pending[bus.i_issue_addr] <= 1'b1;
    end
  end

  // Read ports with writeback bypass; x0 and INIT always read zero, not busy
  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    for (int k = 0; k < NREAD; k++) begin
      if (w_run && bus.i_rd_addr[k*AW +: AW] != '0) begin
        if (bus.i_we && bus.i_dest_addr == bus.i_rd_addr[k*AW +: AW]) begin
          w_rd_data[k*XLEN +: XLEN] = bus.i_data;
          w_rd_busy[k]              = 1'b0;
        end else begin
          w_rd_data[k*XLEN +: XLEN] = r_regs[bus.i_rd_addr[k*AW +: AW]];
          w_rd_busy[k]              = r_pending[bus.i_rd_addr[k*AW +: AW]];
        end
      end
    end
  end

  assign bus.o_rd_data = w_rd_data;
  assign bus.o_rd_busy = w_rd_busy;
  assign bus.o_ready   = w_run;
endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb
module tb_regfile_sb;
  logic clk;
  logic rst_a;
  logic rst_b;
  int   n_checks;
  int   n_errors;
  int   cycles;

  regfile_sb_if #(.XLEN(32), .NREGS(32), .NREAD(2)) ifa ();
  regfile_sb_if #(.XLEN(64), .NREGS(16), .NREAD(3)) ifb ();

  regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (ifa)
  );

  regfile_sb #(.XLEN(64), .NREGS(16), .NREAD(3)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.i_we = 1'b0; ifa.i_dest_addr = '0; ifa.i_data = '0;
    ifa.i_issue_valid = 1'b0; ifa.i_issue_addr = '0; ifa.i_rd_addr = '0;
    ifb.i_we = 1'b0; ifb.i_dest_addr = '0; ifb.i_data = '0;
    ifb.i_issue_valid = 1'b0; ifb.i_issue_addr = '0; ifb.i_rd_addr = '0;

    // ---- reset sweep, NREGS=32 ----
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0;
    check("rst_ready", 64'(ifa.o_ready), 64'd0);
    check("rst_busy", 64'(ifa.o_rd_busy), 64'd0);
    ifa.i_we = 1'b1; ifa.i_dest_addr = 5'd5; ifa.i_data = 32'hDEAD;
    ifa.i_rd_addr = {5'd5, 5'd5};
    ifa.i_issue_valid = 1'b1; ifa.i_issue_addr = 5'd6;
    #1;
    check("init_rd_data", 64'(ifa.o_rd_data), 64'd0);
    cycles = 0;
    while (!ifa.o_ready && cycles < 100) begin
      tick();
      cycles++;
      if (cycles == 4) begin
        ifa.i_we = 1'b0;
        ifa.i_issue_valid = 1'b0;
      end
    end
    check("sweep_len_32", 64'(cycles), 64'd32);
    for (int i = 0; i < 32; i += 2) begin
      ifa.i_rd_addr = {5'(i + 1), 5'(i)};
      #1;
      check("sweep_rd", 64'(ifa.o_rd_data), 64'd0);
      check("sweep_busy", 64'(ifa.o_rd_busy), 64'd0);
    end

    // ---- bypass and x0 ----
    ifa.i_we = 1'b1; ifa.i_dest_addr = 5'd7; ifa.i_data = 32'h1234_5678;
    ifa.i_rd_addr = {5'd0, 5'd7};
    #1;
    check("bypass_same", 64'(ifa.o_rd_data[31:0]), 64'h1234_5678);
    tick();
    ifa.i_we = 1'b0;
    #1;
    check("bypass_after", 64'(ifa.o_rd_data[31:0]), 64'h1234_5678);
    ifa.i_we = 1'b1; ifa.i_dest_addr = 5'd0; ifa.i_data = 32'hFFFF_FFFF;
    ifa.i_rd_addr = {5'd0, 5'd0};
    #1;
    check("x0_same", 64'(ifa.o_rd_data), 64'd0);
    tick();
    ifa.i_we = 1'b0;
    #1;
    check("x0_after", 64'(ifa.o_rd_data), 64'd0);

    // ---- scoreboard ----
    ifa.i_issue_valid = 1'b1; ifa.i_issue_addr = 5'd9;
    ifa.i_rd_addr = {5'd9, 5'd0};
    #1;
    check("issue_same_cycle", 64'(ifa.o_rd_busy[1]), 64'd0);
    tick();
    ifa.i_issue_valid = 1'b0;
    #1;
    check("issue_busy", 64'(ifa.o_rd_busy[1]), 64'd1);
    ifa.i_we = 1'b1; ifa.i_dest_addr = 5'd9; ifa.i_data = 32'hAA;
    #1;
    check("wb_busy_same", 64'(ifa.o_rd_busy[1]), 64'd0);
    check("wb_data_same", 64'(ifa.o_rd_data[63:32]), 64'hAA);
    tick();
    ifa.i_we = 1'b0;
    #1;
    check("wb_busy_after", 64'(ifa.o_rd_busy[1]), 64'd0);
    check("wb_data_after", 64'(ifa.o_rd_data[63:32]), 64'hAA);
    ifa.i_issue_valid = 1'b1; ifa.i_issue_addr = 5'd0;
    ifa.i_rd_addr = {5'd9, 5'd0};
    tick();
    ifa.i_issue_valid = 1'b0;
    #1;
    check("issue_x0_busy", 64'(ifa.o_rd_busy), 64'd0);

    // ---- issue and write collision ----
    ifa.i_issue_valid = 1'b1; ifa.i_issue_addr = 5'd4;
    tick();
    ifa.i_we = 1'b1; ifa.i_dest_addr = 5'd4; ifa.i_data = 32'h55;
    ifa.i_rd_addr = {5'd0, 5'd4};
    #1;
    check("coll_bypass_busy", 64'(ifa.o_rd_busy[0]), 64'd0);
    tick();
    ifa.i_we = 1'b0; ifa.i_issue_valid = 1'b0;
    #1;
    check("coll_data", 64'(ifa.o_rd_data[31:0]), 64'h55);
    check("coll_busy", 64'(ifa.o_rd_busy[0]), 64'd1);

    // ---- mid-operation reset ----
    ifa.i_we = 1'b1; ifa.i_dest_addr = 5'd3; ifa.i_data = 32'h77;
    tick();
    ifa.i_we = 1'b0;
    ifa.i_issue_valid = 1'b1; ifa.i_issue_addr = 5'd3;
    tick();
    ifa.i_issue_valid = 1'b0;
    ifa.i_rd_addr = {5'd3, 5'd3};
    #1;
    check("pre_rst_data", 64'(ifa.o_rd_data[31:0]), 64'h77);
    check("pre_rst_busy", 64'(ifa.o_rd_busy), 64'd3);
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    check("midrst_ready", 64'(ifa.o_ready), 64'd0);
    cycles = 0;
    while (!ifa.o_ready && cycles < 100) begin
      tick();
      cycles++;
    end
    check("midrst_sweep_len", 64'(cycles), 64'd32);
    check("midrst_data", 64'(ifa.o_rd_data), 64'd0);
    check("midrst_busy", 64'(ifa.o_rd_busy), 64'd0);

    // ---- parameter variant: NREGS=16, NREAD=3, XLEN=64 ----
    rst_b = 1'b0;
    check("b_rst_ready", 64'(ifb.o_ready), 64'd0);
    cycles = 0;
    while (!ifb.o_ready && cycles < 100) begin
      tick();
      cycles++;
    end
    check("b_sweep_len_16", 64'(cycles), 64'd16);
    ifb.i_we = 1'b1; ifb.i_dest_addr = 4'd2; ifb.i_data = 64'h1111_2222_3333_4444;
    tick();
    ifb.i_dest_addr = 4'd5; ifb.i_data = 64'hA5A5_0000_5A5A_FFFF;
    tick();
    ifb.i_dest_addr = 4'd10; ifb.i_data = 64'hCAFE_BABE_DEAD_BEEF;
    ifb.i_rd_addr = {4'd10, 4'd5, 4'd2};
    #1;
    check("b_port0", ifb.o_rd_data[63:0], 64'h1111_2222_3333_4444);
    check("b_port1", ifb.o_rd_data[127:64], 64'hA5A5_0000_5A5A_FFFF);
    check("b_port2_bypass", ifb.o_rd_data[191:128], 64'hCAFE_BABE_DEAD_BEEF);
    tick();
    ifb.i_we = 1'b0;
    ifb.i_issue_valid = 1'b1; ifb.i_issue_addr = 4'd5;
    tick();
    ifb.i_issue_valid = 1'b0;
    ifb.i_rd_addr = {4'd5, 4'd5, 4'd5};
    #1;
    for (int k = 0; k < 3; k++) begin
      check("b_same_data", ifb.o_rd_data[k*64 +: 64], 64'hA5A5_0000_5A5A_FFFF);
    end
    check("b_same_busy", 64'(ifb.o_rd_busy), 64'd7);
    ifb.i_rd_addr = {4'd0, 4'd10, 4'd2};
    #1;
    check("b_reg10", ifb.o_rd_data[127:64], 64'hCAFE_BABE_DEAD_BEEF);
    check("b_x0", ifb.o_rd_data[191:128], 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
